// File: rtl/instr_fetch_if.sv
// Bundle of the fetch unit's controller-facing and memory-facing signals.
// The slave modport is the fetch unit itself; the master modport is the
// side that drives requests and returns memory data.
interface instr_fetch_if #(
    parameter int ADDR_W = 9
);
    logic              fetch_req;
    logic              load_pc;
    logic [ADDR_W-1:0] pc_in;
    logic [15:0]       mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [15:0]       ir;
    logic              ir_valid;
    logic              busy;
    logic              halted;
    logic [ADDR_W-1:0] pc;

    modport master (
        output fetch_req, load_pc, pc_in, mem_rdata,
        input  mem_addr, mem_rd, ir, ir_valid, busy, halted, pc
    );

    modport slave (
        input  fetch_req, load_pc, pc_in, mem_rdata,
        output mem_addr, mem_rd, ir, ir_valid, busy, halted, pc
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: holds the PC, issues one-cycle read strobes to
// instruction memory, waits MEM_LAT cycles and captures the returned word
// into the instruction register that drives the decoder. A HALT opcode
// (3'b111) freezes the PC and blocks further fetches until the PC is loaded.
module instr_fetch #(
    parameter int                ADDR_W   = 9,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                MEM_LAT  = 1
) (
    input logic            clk,
    input logic            reset_n,
    instr_fetch_if.slave   bus
);

    localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  wcnt;
    logic [ADDR_W-1:0] pc_q;
    logic [15:0]       ir_q;
    logic              ir_valid_q;
    logic              halted_q;
    logic              mem_rd_c;
    logic              busy_c;
    logic              last_wait;
    logic              capture;
    logic              start;

    // last_wait marks the cycle whose read data is valid; a PC load in that
    // same cycle wins and suppresses the capture
    assign last_wait = (state == S_WAIT) && (wcnt == CNT_W'(MEM_LAT));
    assign capture   = last_wait && !bus.load_pc;
    assign start     = (state == S_IDLE) && bus.fetch_req && !halted_q;

    // State register, synchronously reset to IDLE
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a PC load aborts any fetch in flight
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.load_pc) begin
                    state_next = S_IDLE;
                end else begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.load_pc || last_wait) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs decoded purely from registered state
    always_comb begin
        mem_rd_c = (state == S_REQ);
        busy_c   = (state != S_IDLE);
    end

    // Datapath: PC, instruction register, flags and the latency counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q       <= RESET_PC;
            ir_q       <= 16'h0000;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            wcnt       <= '0;
        end else begin
            if (bus.load_pc) begin
                pc_q       <= bus.pc_in;
                ir_valid_q <= 1'b0;
                halted_q   <= 1'b0;
            end else if (capture) begin
                ir_q       <= bus.mem_rdata;
                ir_valid_q <= 1'b1;
                if (bus.mem_rdata[15:13] == 3'b111) begin
                    halted_q <= 1'b1;
                end else begin
                    pc_q <= pc_q + ADDR_W'(1);
                end
            end else if (start) begin
                ir_valid_q <= 1'b0;
            end

            if (state == S_REQ) begin
                wcnt <= CNT_W'(1);
            end else if (state == S_WAIT) begin
                wcnt <= wcnt + CNT_W'(1);
            end
        end
    end

    assign bus.mem_addr = pc_q;
    assign bus.pc       = pc_q;
    assign bus.ir       = ir_q;
    assign bus.ir_valid = ir_valid_q;
    assign bus.halted   = halted_q;
    assign bus.mem_rd   = mem_rd_c;
    assign bus.busy     = busy_c;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch with MEM_LAT=1, ADDR_W=9, RESET_PC=0.
// A small memory array answers reads combinationally from mem_addr, which
// holds steady for the whole fetch, so data is valid in the WAIT cycle.
module tb_instr_fetch;

    logic clk;
    logic reset_n;
    int   errors;
    int   checks;

    logic [15:0] mem [512];

    instr_fetch_if #(.ADDR_W(9)) bus ();

    instr_fetch #(
        .ADDR_W   (9),
        .RESET_PC (9'h000),
        .MEM_LAT  (1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    assign bus.mem_rdata = mem[bus.mem_addr];

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic fetchReq, input logic loadPc, input logic [8:0] pcIn);
        bus.fetch_req = fetchReq;
        bus.load_pc   = loadPc;
        bus.pc_in     = pcIn;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Linear directed sequence covering each scenario in turn
    initial begin
        errors  = 0;
        checks  = 0;
        reset_n = 1'b0;
        for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
        mem[0]       = 16'hD105;
        mem[1]       = 16'hD203;
        mem[2]       = 16'hA0C2;
        mem[9'h1FF]  = 16'h1234;
        mem[9'h020]  = 16'hE000;
        mem[9'h005]  = 16'hABCD;
        applyStimulus(1'b0, 1'b0, 9'h000);
        step();
        step();
        reset_n = 1'b1;

        // Reset state
        checkOutput("rst_pc",       32'(bus.pc),       32'h000);
        checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'h000);
        checkOutput("rst_ir",       32'(bus.ir),       32'h0000);
        checkOutput("rst_ir_valid", 32'(bus.ir_valid), 32'd0);
        checkOutput("rst_busy",     32'(bus.busy),     32'd0);
        checkOutput("rst_halted",   32'(bus.halted),   32'd0);
        checkOutput("rst_mem_rd",   32'(bus.mem_rd),   32'd0);

        // Basic fetch: single-cycle request
        applyStimulus(1'b1, 1'b0, 9'h000);
        step();
        applyStimulus(1'b0, 1'b0, 9'h000);
        checkOutput("basic_mem_rd",   32'(bus.mem_rd),   32'd1);
        checkOutput("basic_mem_addr", 32'(bus.mem_addr), 32'h000);
        checkOutput("basic_busy_req", 32'(bus.busy),     32'd1);
        step();
        checkOutput("basic_mem_rd_wait", 32'(bus.mem_rd), 32'd0);
        checkOutput("basic_busy_wait",   32'(bus.busy),   32'd1);
        step();
        checkOutput("basic_ir",       32'(bus.ir),       32'hD105);
        checkOutput("basic_ir_valid", 32'(bus.ir_valid), 32'd1);
        checkOutput("basic_pc",       32'(bus.pc),       32'h001);
        checkOutput("basic_busy",     32'(bus.busy),     32'd0);

        // Back-to-back fetches from address 0 with fetch_req held high
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 9'h000);
        for (int i = 0; i < 9; i++) begin
            step();
            checkOutput($sformatf("b2b_mem_rd_%0d", i), 32'(bus.mem_rd), (i % 3 == 0) ? 32'd1 : 32'd0);
            if (i % 3 == 0) begin
                checkOutput($sformatf("b2b_ir_valid_fall_%0d", i), 32'(bus.ir_valid), 32'd0);
            end
            if (i % 3 == 2) begin
                checkOutput($sformatf("b2b_ir_%0d", i), 32'(bus.ir),
                            (i / 3 == 0) ? 32'hD105 : (i / 3 == 1) ? 32'hD203 : 32'hA0C2);
                checkOutput($sformatf("b2b_pc_%0d", i), 32'(bus.pc), 32'(i / 3 + 1));
            end
        end
        applyStimulus(1'b0, 1'b0, 9'h000);
        checkOutput("b2b_pc_final", 32'(bus.pc), 32'h003);

        // Simultaneous load of 0x1FF and fetch request, then wrap to 0
        applyStimulus(1'b1, 1'b1, 9'h1FF);
        step();
        applyStimulus(1'b0, 1'b0, 9'h000);
        checkOutput("wrap_mem_rd",   32'(bus.mem_rd),   32'd1);
        checkOutput("wrap_mem_addr", 32'(bus.mem_addr), 32'h1FF);
        step();
        step();
        checkOutput("wrap_ir",       32'(bus.ir),       32'h1234);
        checkOutput("wrap_ir_valid", 32'(bus.ir_valid), 32'd1);
        checkOutput("wrap_pc",       32'(bus.pc),       32'h000);

        // Flush during WAIT while memory presents 0xBEEF
        mem[0] = 16'hBEEF;
        applyStimulus(1'b1, 1'b0, 9'h000);
        step();
        applyStimulus(1'b0, 1'b0, 9'h000);
        step();
        checkOutput("flush_in_wait", 32'(bus.busy), 32'd1);
        applyStimulus(1'b0, 1'b1, 9'h020);
        step();
        applyStimulus(1'b0, 1'b0, 9'h000);
        checkOutput("flush_ir",       32'(bus.ir),       32'h1234);
        checkOutput("flush_ir_valid", 32'(bus.ir_valid), 32'd0);
        checkOutput("flush_pc",       32'(bus.pc),       32'h020);
        checkOutput("flush_busy",     32'(bus.busy),     32'd0);
        step();
        checkOutput("flush_ir_later",   32'(bus.ir),   32'h1234);
        checkOutput("flush_busy_later", 32'(bus.busy), 32'd0);
        mem[0] = 16'hD105;

        // HALT at 0x020, then fetch requests are ignored until a PC load
        applyStimulus(1'b1, 1'b0, 9'h000);
        step();
        applyStimulus(1'b0, 1'b0, 9'h000);
        step();
        step();
        checkOutput("halt_ir",       32'(bus.ir),       32'hE000);
        checkOutput("halt_halted",   32'(bus.halted),   32'd1);
        checkOutput("halt_pc",       32'(bus.pc),       32'h020);
        checkOutput("halt_ir_valid", 32'(bus.ir_valid), 32'd1);
        applyStimulus(1'b1, 1'b0, 9'h000);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput($sformatf("halt_no_mem_rd_%0d", i), 32'(bus.mem_rd), 32'd0);
            checkOutput($sformatf("halt_no_busy_%0d", i),   32'(bus.busy),   32'd0);
        end
        applyStimulus(1'b0, 1'b1, 9'h005);
        step();
        applyStimulus(1'b0, 1'b0, 9'h000);
        checkOutput("halt_cleared",       32'(bus.halted),   32'd0);
        checkOutput("halt_load_pc",       32'(bus.pc),       32'h005);
        checkOutput("halt_load_ir_valid", 32'(bus.ir_valid), 32'd0);

        // Reset asserted during WAIT aborts the fetch with no capture
        applyStimulus(1'b1, 1'b0, 9'h000);
        step();
        applyStimulus(1'b0, 1'b0, 9'h000);
        step();
        checkOutput("rstmid_in_wait", 32'(bus.busy), 32'd1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        checkOutput("rstmid_pc",       32'(bus.pc),       32'h000);
        checkOutput("rstmid_ir",       32'(bus.ir),       32'h0000);
        checkOutput("rstmid_ir_valid", 32'(bus.ir_valid), 32'd0);
        checkOutput("rstmid_busy",     32'(bus.busy),     32'd0);
        checkOutput("rstmid_halted",   32'(bus.halted),   32'd0);
        checkOutput("rstmid_mem_rd",   32'(bus.mem_rd),   32'd0);
        applyStimulus(1'b1, 1'b0, 9'h000);
        step();
        applyStimulus(1'b0, 1'b0, 9'h000);
        checkOutput("rstmid_refetch_rd",   32'(bus.mem_rd),   32'd1);
        checkOutput("rstmid_refetch_addr", 32'(bus.mem_addr), 32'h000);
        step();
        step();
        checkOutput("rstmid_refetch_ir", 32'(bus.ir), 32'hD105);
        checkOutput("rstmid_refetch_pc", 32'(bus.pc), 32'h001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
